// File: rtl/piso_arb_pkg.sv
// Shared definitions for the PISO transmit arbiter.
//   state_t   : sequencer states (IDLE -> SHIFT -> GAP -> IDLE)
//   OWN_W     : owner index width for the default requester count
//   rr_pick() : round-robin winner search starting after a base index
package piso_arb_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 4;
    localparam int OWN_W      = $clog2(N_REQ_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Returns the first set bit of req_vec visiting base+1, base+2, ...
    // modulo n. The base itself is visited last. Supports n up to 8.
    // Returns 0 when nothing is set; callers only use it with |req.
    function automatic int rr_pick(input int base, input logic [7:0] req_vec,
                                   input int n);
        int  pick;
        int  idx;
        logic found;
        pick  = 0;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = (base + i) % n;
            if (!found && (i <= n) && req_vec[idx[2:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Parallel-in / serial-out shift register, LSB first.
//   clk, rst : clock, asynchronous active-low reset
//   load     : capture d (takes priority over shift)
//   shift    : shift right by one, filling with zero
//   d        : parallel word
//   q0       : current serial bit (register bit 0)
module piso_shift_core #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] d,
    output logic              q0
);

    logic [DATA_W-1:0] r_sreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sreg <= '0;
        end else if (load) begin
            r_sreg <= d;
        end else if (shift) begin
            r_sreg <= {1'b0, r_sreg[DATA_W-1:1]};
        end
    end

    assign q0 = r_sreg[0];

endmodule

// File: rtl/piso_tx_arbiter.sv
// Round-robin arbiter sharing one PISO shifter among N_REQ requesters.
// A granted word is loaded, sent LSB first for DATA_W cycles with
// ser_valid high, then one idle gap cycle before re-arbitration.
//   clk, rst    : clock, asynchronous active-low reset
//   en          : allows a new grant (only looked at in IDLE)
//   req, data   : per-requester request and flattened words
//   ack         : one-cycle one-hot pulse in the cycle after the load edge
//   ser_out     : serial bit, forced to 0 outside ser_valid
//   ser_valid   : high during the DATA_W bit cycles of a frame
//   busy        : high during SHIFT and GAP
//   owner       : index of the current/last granted requester
//   o_dbg_state : current sequencer state (state_t encoding)
//
// Handshake: a requester holds req high with data stable; the grant edge
// captures data and raises ack[i] for exactly one cycle. The requester
// may drop or advance req/data at the following edge. Requests seen
// outside IDLE are simply left pending.
module piso_tx_arbiter
    import piso_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data,
    output logic [N_REQ-1:0]          ack,
    output logic                      ser_out,
    output logic                      ser_valid,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic [1:0]                o_dbg_state
);

    localparam int OWN_BITS = $clog2(N_REQ);
    localparam int CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [OWN_BITS-1:0]   r_last, w_last_nxt;
    logic [OWN_BITS-1:0]   r_owner, w_owner_nxt;
    logic [N_REQ-1:0]      r_ack, w_ack_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  w_load, w_shift;
    logic [7:0]            w_req8;
    logic [OWN_BITS-1:0]   w_pick;
    logic [DATA_W-1:0]     w_load_word;
    logic                  w_q0;

    assign w_load_word = data[int'(w_pick)*DATA_W +: DATA_W];

    piso_shift_core #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .shift (w_shift),
        .d     (w_load_word),
        .q0    (w_q0)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= OWN_BITS'(N_REQ - 1);  // requester 0 wins first
            r_owner <= '0;
            r_ack   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_owner <= w_owner_nxt;
            r_ack   <= w_ack_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_req8              = '0;
        w_req8[N_REQ-1:0]   = req;
        w_pick              = OWN_BITS'(rr_pick(int'(r_last), w_req8, N_REQ));

        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_owner_nxt = r_owner;
        w_ack_nxt   = '0;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_load      = 1'b0;
        w_shift     = 1'b0;

        case (r_state)
            IDLE: begin
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                if (en && |req) begin
                    w_load      = 1'b1;
                    for (int i = 0; i < N_REQ; i++) begin
                        w_ack_nxt[i] = (w_pick == OWN_BITS'(i));
                    end
                    w_owner_nxt = w_pick;
                    w_last_nxt  = w_pick;
                    w_cnt_nxt   = '0;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_shift   = 1'b1;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // Last bit is on the line this cycle; next cycle is the gap.
                if (r_cnt == CNT_LAST) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ack         = r_ack;
    assign ser_valid   = r_valid;
    assign ser_out     = r_valid & w_q0;
    assign busy        = r_busy;
    assign owner       = r_owner;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_piso_tx_arbiter.sv
module tb_piso_tx_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 4;
    localparam int OWN_W  = $clog2(N_REQ);
    localparam int EXP_W  = 32 + 8 + DATA_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                     en;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*DATA_W-1:0]  data;
    logic [N_REQ-1:0]         ack;
    logic                     ser_out;
    logic                     ser_valid;
    logic                     busy;
    logic [OWN_W-1:0]         owner;
    logic [1:0]               dbg_state;

    piso_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .data        (data),
        .ack         (ack),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .busy        (busy),
        .owner       (owner),
        .o_dbg_state (dbg_state)
    );

    // ---------------- producers ----------------
    logic [DATA_W-1:0] word_r [N_REQ];
    int                left_r [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req[i]                     = (left_r[i] > 0);
            data[i*DATA_W +: DATA_W]   = word_r[i];
        end
    end

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // A frame occupies the grant edge plus DATA_W+1 further cycles
    // (DATA_W bits then the gap). While m_left > 0 no new grant happens.
    logic [EXP_W-1:0] exp_q[$];
    int               m_cyc   = 0;
    int               m_left  = 0;
    int               m_last  = N_REQ - 1;
    int               m_owner = 0;
    int               m_g;
    int               m_idx;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left  = 0;
            m_last  = N_REQ - 1;
            m_owner = 0;
            exp_q.delete();
        end else begin
            m_cyc++;
            if (m_left > 0) begin
                m_left--;
            end else if (en && (req != '0)) begin
                m_g = -1;
                for (int k = 1; k <= N_REQ; k++) begin
                    m_idx = (m_last + k) % N_REQ;
                    if (m_g < 0 && req[m_idx]) m_g = m_idx;
                end
                m_last  = m_g;
                m_owner = m_g;
                exp_q.push_back({32'(m_cyc), 8'(m_g), word_r[m_g]});
                m_left  = DATA_W + 1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [EXP_W-1:0]  mon_e;
    logic [N_REQ-1:0]  mon_ack_exp;
    logic [DATA_W-1:0] mon_word = '0;
    int                mon_g;

    always @(negedge clk) begin
        mon_ack_exp = '0;
        if (rst && exp_q.size() > 0 && int'(exp_q[0][EXP_W-1 -: 32]) <= m_cyc) begin
            mon_e       = exp_q.pop_front();
            mon_g       = int'(mon_e[DATA_W +: 8]);
            mon_ack_exp = N_REQ'(1) << mon_g;
            mon_word    = mon_e[DATA_W-1:0];
        end
        chk("ack", 32'(ack), 32'(mon_ack_exp));
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("ser_valid", 32'(ser_valid), 32'(m_left >= 2));
        chk("owner", 32'(owner), 32'(m_owner));
        if (m_left >= 2)
            chk("ser_bit", 32'(ser_out), 32'(mon_word[DATA_W + 1 - m_left]));
        else
            chk("ser_idle_zero", 32'(ser_out), 32'(0));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (ack[i] && left_r[i] > 0) begin
                left_r[i]--;
                if (left_r[i] > 0) word_r[i] = DATA_W'($urandom);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N_REQ; i++) left_r[i] = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"},       32'(ack),       32'(0));
        chk({tag, "_ser_out"},   32'(ser_out),   32'(0));
        chk({tag, "_ser_valid"}, 32'(ser_valid), 32'(0));
        chk({tag, "_busy"},      32'(busy),      32'(0));
        chk({tag, "_owner"},     32'(owner),     32'(0));
        chk({tag, "_state"},     32'(dbg_state), 32'(0));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset(input string tag);
        #2 rst = 1'b0;
        #1 check_reset_outputs(tag);
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic wait_ack(input int i, input int limit);
        int n;
        n = 0;
        while (!ack[i] && n < limit) begin
            tick();
            n++;
        end
        chk("wait_ack_timeout", 32'(ack[i]), 32'(1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic all_idle;
        en = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            word_r[i] = '0;
            left_r[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("por");
        @(negedge clk);
        #2 rst = 1'b1;

        // single request on requester 1
        en = 1'b1;
        word_r[1] = 4'b1011;
        left_r[1] = 1;
        run(10);

        // simultaneous 0 and 2 right after reset
        do_reset("rst_a");
        word_r[0] = 4'b0110; left_r[0] = 1;
        word_r[2] = 4'b1001; left_r[2] = 1;
        run(16);

        // all four continuous
        do_reset("rst_b");
        for (int i = 0; i < N_REQ; i++) begin
            word_r[i] = DATA_W'($urandom);
            left_r[i] = 2;
        end
        run(52);
        clear_reqs();
        run(8);

        // en low blocks grants
        en = 1'b0;
        word_r[3] = 4'b0101;
        left_r[3] = 1;
        run(10);
        en = 1'b1;
        run(10);

        // requester 3 arrives during requester 1's frame
        word_r[1] = DATA_W'($urandom);
        left_r[1] = 1;
        wait_ack(1, 10);
        tick();
        word_r[3] = DATA_W'($urandom);
        left_r[3] = 1;
        run(16);

        // reset mid-frame after two bits; requester 0 wins again after release
        do_reset("rst_c");
        word_r[0] = DATA_W'($urandom); left_r[0] = 2;
        word_r[2] = DATA_W'($urandom); left_r[2] = 1;
        wait_ack(0, 10);
        tick();
        tick();
        do_reset("rst_mid");
        run(20);

        // randomized traffic
        for (int r = 0; r < 600; r++) begin
            en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < N_REQ; i++) begin
                if (left_r[i] == 0 && $urandom_range(0, 5) == 0) begin
                    word_r[i] = DATA_W'($urandom);
                    left_r[i] = $urandom_range(1, 3);
                end else if (left_r[i] > 0 && $urandom_range(0, 40) == 0) begin
                    left_r[i] = 0;
                end
            end
            if (r == 300) do_reset("rst_rand");
            tick();
        end

        // drain
        en = 1'b1;
        n = 0;
        all_idle = 1'b0;
        while (!all_idle && n < 300) begin
            tick();
            n++;
            all_idle = !busy;
            for (int i = 0; i < N_REQ; i++) if (left_r[i] > 0) all_idle = 1'b0;
        end
        chk("drain_timeout", 32'(all_idle), 32'(1));
        run(2);
        chk("exp_q_empty", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (checks %0d/%0d)", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/piso_tx_arbiter.md
Name: piso_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one parallel-in/serial-out shifter among N_REQ parallel requesters.
- Each granted word is loaded, shifted out LSB-first over DATA_W cycles with a qualifying valid strobe, then followed by one idle gap cycle.
- Sits between parallel producers and a single serial link or pin.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 4, bits per serial word (2..16).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active-low.
- en  input  1  arbitration enable; sampled only in IDLE.
- req  input  N_REQ  per-requester request; held high with data stable until ack.
- data  input  N_REQ*DATA_W  flattened words; requester i uses bits [i*DATA_W +: DATA_W].
- ack  output  N_REQ  registered one-hot, one-cycle pulse on grant/load.
- ser_out  output  1  serial data, LSB first.
- ser_valid  output  1  high exactly during the DATA_W bit cycles of a frame.
- busy  output  1  high in SHIFT and GAP.
- owner  output  $clog2(N_REQ)  index of the current/last granted requester.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, shift reg=0, bit counter=0.
  - ack=0, ser_valid=0, busy=0, owner=0, ser_out=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has top priority first.
- Reset asserted mid-frame aborts the frame immediately.
  - Outputs are forced to reset values; no partial frame resumes after reset release.
- States: IDLE -> SHIFT -> GAP -> IDLE.
- IDLE: at a posedge with en=1 and |req:
  - Winner g is the first set req bit searching last+1, last+2, ... modulo N_REQ.
  - Shift reg <= data[g]; ack <= onehot(g); owner <= g; last <= g.
  - cnt <= 0; ser_valid <= 1; busy <= 1; state <= SHIFT.
  - With en=0 or req=0: stay in IDLE, all strobes 0.
- SHIFT: ser_out = shift reg[0].
  - Each posedge: shift reg <= {1'b0, reg[DATA_W-1:1]}, cnt++.
  - When cnt == DATA_W-1 at the edge: ser_valid <= 0, state <= GAP.
  - ser_valid is therefore high for exactly DATA_W cycles, starting the cycle after the load edge.
- GAP: one cycle with ser_valid=0, busy=1; then state <= IDLE, busy <= 0.
- ack timing: high only in the cycle following the load edge; cleared at the next edge.
  - The requester drops or advances its req at that edge.
- req changes during SHIFT/GAP are ignored; a pending req waits for IDLE.
- A req dropped before grant is never acked.
- en dropping mid-frame does not affect the current frame; it only blocks the next grant.
- Throughput: one frame per DATA_W+2 cycles when requests are continuous (load edge, DATA_W bits, gap, re-arbitrate).
- ser_out=0 whenever ser_valid=0.
- Simultaneous requests: exactly one ack bit is ever set at a time.

Decomposition:
- Package piso_arb_pkg holds:
  - state enum {IDLE, SHIFT, GAP};
  - the localparam OWN_W = $clog2(N_REQ);
  - a round-robin pick function (base index, request vector) -> index.
- Sub-module piso_shift_core (DATA_W parameter; load, shift, d, q0; async active-low rst) holds the shift register.
- The arbiter FSM, counter and pointer stay in the top module.

Test Plan:
- Single request: req=4'b0010, data[1]=4'b1011, en=1.
  -> ack=4'b0010 for one cycle, owner=1.
  -> ser_out 1,1,0,1 over 4 ser_valid cycles, then 1 gap cycle; busy high for 5 cycles.
- Simultaneous req=4'b0101 after reset, data[0]=4'b0110, data[2]=4'b1001.
  -> requester 0 first (0,1,1,0), gap, then requester 2 (1,0,0,1).
  -> Second ack arrives exactly 6 cycles after the first.
- All four requests held continuously.
  -> Grant order 0,1,2,3,0,1; no ack overlap; ser_valid low exactly one cycle between frames.
- en=0 with req=4'b1000 for 10 cycles -> no ack, busy=0; en=1 -> ack[3] at the next IDLE edge.
- Requester 3 asserts req during requester 1's SHIFT -> not acked until after GAP; its frame starts 1 cycle after IDLE is re-entered.
- rst pulled low after the 2nd bit of a frame.
  -> All outputs 0 immediately.
  -> After release with req still held, the frame restarts from bit 0 and the requester is re-acked; requester 0 regains priority.
